// File: rtl/traffic_phase_controller_if.sv
// Bus between the junction phase sequencer and its environment.
// Optional macro: EMERGENCY_PREEMPT_EN adds the emerg request vector.
interface traffic_phase_controller_if #(
    parameter int unsigned NUM_BOARDS = 4
);
    localparam int unsigned SEL_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

    logic                      tick_en;
    logic [NUM_BOARDS-1:0]     req;
`ifdef EMERGENCY_PREEMPT_EN
    logic [NUM_BOARDS-1:0]     emerg;
`endif
    logic [SEL_W-1:0]          board_sel;
    logic [NUM_BOARDS-1:0]     board_onehot;
    logic [2*NUM_BOARDS-1:0]   lights;
    logic [1:0]                phase;
    logic                      cycle_done;

    // Environment side: drives timebase and demand, observes the lights.
    modport master (
`ifdef EMERGENCY_PREEMPT_EN
        output emerg,
`endif
        output tick_en,
        output req,
        input  board_sel,
        input  board_onehot,
        input  lights,
        input  phase,
        input  cycle_done
    );

    // Controller side.
    modport slave (
`ifdef EMERGENCY_PREEMPT_EN
        input  emerg,
`endif
        input  tick_en,
        input  req,
        output board_sel,
        output board_onehot,
        output lights,
        output phase,
        output cycle_done
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// Demand-driven GREEN -> YELLOW -> ALL_RED sequencer for NUM_BOARDS light boards.
// Boards without demand are skipped; green rests on the current board while nobody else asks.
// Optional macro: EMERGENCY_PREEMPT_EN enables emergency preemption via bus.emerg.
module traffic_phase_controller #(
    parameter int unsigned NUM_BOARDS   = 4,
    parameter int unsigned GREEN_TICKS  = 16,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned CNT_W        = 8
) (
    input logic                      clk,
    input logic                      rst,
    traffic_phase_controller_if.slave bus
);
    localparam int unsigned SEL_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

    localparam logic [CNT_W-1:0] GreenLoad  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YellowLoad = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] AllRedLoad = CNT_W'(ALLRED_TICKS - 1);

    // Phase codes double as the light code of the owning board.
    typedef enum logic [1:0] {
        PhAllRed = 2'b00,
        PhGreen  = 2'b01,
        PhYellow = 2'b10
    } phase_e;

    phase_e                  phase_q, phase_d;
    logic [SEL_W-1:0]        board_sel_q, board_sel_d;
    logic [NUM_BOARDS-1:0]   board_onehot_q, board_onehot_d;
    logic [2*NUM_BOARDS-1:0] lights_q, lights_d;
    logic                    cycle_done_q, cycle_done_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    first_q, first_d;

    logic [NUM_BOARDS-1:0]   other_req;
    logic [SEL_W-1:0]        next_board;
    logic [SEL_W-1:0]        grant_board;

    assign other_req = bus.req & ~board_onehot_q;

`ifdef EMERGENCY_PREEMPT_EN
    logic             emerg_any;
    logic [SEL_W-1:0] emerg_win;

    // Lowest set emerg index wins.
    always_comb begin
        emerg_any = |bus.emerg;
        emerg_win = '0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (bus.emerg[SEL_W'(i)]) begin
                emerg_win = SEL_W'(i);
            end
        end
    end
`endif

    // Round-robin search for the next requesting board, current board last.
    // After reset the search starts at index 0 inclusive (base = NUM_BOARDS-1).
    always_comb begin
        int unsigned base;
        int unsigned idx;
        logic        found;
        base  = first_q ? (NUM_BOARDS - 1) : int'(board_sel_q);
        idx   = 0;
        found = 1'b0;
        next_board = SEL_W'((base + 1) % NUM_BOARDS);
        for (int unsigned k = 1; k <= NUM_BOARDS; k++) begin
            idx = (base + k) % NUM_BOARDS;
            if (!found && bus.req[SEL_W'(idx)]) begin
                found      = 1'b1;
                next_board = SEL_W'(idx);
            end
        end
        grant_board = next_board;
`ifdef EMERGENCY_PREEMPT_EN
        if (emerg_any) begin
            grant_board = emerg_win;
        end
`endif
    end

    // Phase sequencing and tick counter; everything holds while tick_en is low.
    always_comb begin
        phase_d      = phase_q;
        board_sel_d  = board_sel_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        cycle_done_d = 1'b0;
        if (bus.tick_en) begin
            unique case (phase_q)
                PhGreen: begin
`ifdef EMERGENCY_PREEMPT_EN
                    if (emerg_any && (emerg_win != board_sel_q)) begin
                        phase_d = PhYellow;
                        cnt_d   = YellowLoad;
                    end else if (emerg_any) begin
                        // Held green: once released, the normal end rules apply at once.
                        cnt_d = '0;
                    end else
`endif
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (|other_req) begin
                        phase_d = PhYellow;
                        cnt_d   = YellowLoad;
                    end
                end
                PhYellow: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        phase_d = PhAllRed;
                        cnt_d   = AllRedLoad;
                    end
                end
                PhAllRed: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        phase_d      = PhGreen;
                        cnt_d        = GreenLoad;
                        board_sel_d  = grant_board;
                        first_d      = 1'b0;
                        cycle_done_d = !first_q && (grant_board <= board_sel_q);
                    end
                end
                default: begin
                    phase_d = PhAllRed;
                    cnt_d   = AllRedLoad;
                end
            endcase
        end
    end

    // Registered output decode from the next state.
    always_comb begin
        board_onehot_d = NUM_BOARDS'(1) << board_sel_d;
        lights_d       = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (SEL_W'(i) == board_sel_d) begin
                lights_d[2*i +: 2] = phase_d;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q        <= PhAllRed;
            board_sel_q    <= '0;
            board_onehot_q <= NUM_BOARDS'(1);
            lights_q       <= '0;
            cycle_done_q   <= 1'b0;
            cnt_q          <= AllRedLoad;
            first_q        <= 1'b1;
        end else begin
            phase_q        <= phase_d;
            board_sel_q    <= board_sel_d;
            board_onehot_q <= board_onehot_d;
            lights_q       <= lights_d;
            cycle_done_q   <= cycle_done_d;
            cnt_q          <= cnt_d;
            first_q        <= first_d;
        end
    end

    assign bus.board_sel    = board_sel_q;
    assign bus.board_onehot = board_onehot_q;
    assign bus.lights       = lights_q;
    assign bus.phase        = phase_q;
    assign bus.cycle_done   = cycle_done_q;

endmodule
